// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed 7-segment driver: converts a 0-100 roll result to
// decimal by repeated subtraction and time-multiplexes the digits onto one bus.
module seg7_mux_driver #(
  parameter int REFRESH_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] value,
  input  logic       load,
  input  logic       blank,
  input  logic       seg_pol,
  input  logic       com_pol,
  output logic [7:0] seg,
  output logic [1:0] com,
  output logic [1:0] com_oe,
  output logic       busy
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [15:0] LP_LAST = 16'(REFRESH_DIV - 1);

  state_t      r_state;
  logic [6:0]  r_work;
  logic [3:0]  r_tens_acc;
  logic        r_hund_acc;
  logic [3:0]  r_ones_q;
  logic [3:0]  r_tens_q;
  logic        r_hund_q;
  logic        r_shown;
  logic        r_busy;
  logic [15:0] r_cnt;
  logic        r_sel;

  logic        w_tens_on;
  logic        w_en_ones;
  logic        w_en_tens;
  logic [3:0]  w_digit;
  logic [6:0]  w_pat;

  function automatic logic [6:0] f_font(input logic [3:0] d);
    case (d)
      4'd0:    f_font = 7'b0111111;
      4'd1:    f_font = 7'b0000110;
      4'd2:    f_font = 7'b1011011;
      4'd3:    f_font = 7'b1001111;
      4'd4:    f_font = 7'b1100110;
      4'd5:    f_font = 7'b1101101;
      4'd6:    f_font = 7'b1111101;
      4'd7:    f_font = 7'b0000111;
      4'd8:    f_font = 7'b1111111;
      4'd9:    f_font = 7'b1101111;
      default: f_font = 7'b0000000;
    endcase
  endfunction

  // Conversion FSM; display registers only move on the CONV exit step so the
  // previous result stays visible while a new one is being converted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_work     <= '0;
      r_tens_acc <= '0;
      r_hund_acc <= 1'b0;
      r_ones_q   <= '0;
      r_tens_q   <= '0;
      r_hund_q   <= 1'b0;
      r_shown    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_work     <= value;
            r_tens_acc <= '0;
            r_hund_acc <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= CONV;
          end
        end
        CONV: begin
          if (r_work >= 7'd100) begin
            r_work     <= r_work - 7'd100;
            r_hund_acc <= 1'b1;
          end else if (r_work >= 7'd10) begin
            r_work     <= r_work - 7'd10;
            r_tens_acc <= r_tens_acc + 4'd1;
          end else begin
            r_ones_q <= r_work[3:0];
            r_tens_q <= r_tens_acc;
            r_hund_q <= r_hund_acc;
            r_shown  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Free-running refresh counter; each digit phase lasts REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else if (r_cnt == LP_LAST) begin
      r_cnt <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // The hundred flag keeps "00" visible for 100, where the tens count is zero.
  assign w_tens_on = (r_tens_q != 4'd0) || r_hund_q;
  assign w_en_ones = ~r_sel & r_shown & ~blank;
  assign w_en_tens = r_sel & r_shown & ~blank & w_tens_on;
  assign w_digit   = r_sel ? r_tens_q : r_ones_q;
  assign w_pat     = f_font(w_digit);

  assign seg    = (w_en_ones | w_en_tens) ? {~seg_pol, w_pat ~^ {7{seg_pol}}}
                                          : {8{~seg_pol}};
  assign com    = {(w_en_tens ? com_pol : ~com_pol), (w_en_ones ? com_pol : ~com_pol)};
  assign com_oe = 2'b11;
  assign busy   = r_busy;

endmodule
